// File: rtl/kamus_mem_pkg.sv
// Core package shared by the memory-access stage.
// Contents:
//   op_e       - decoded operation enum shared with the execute stage
//   mem_state_e- memory-stage FSM states
//   mem_size_e - access size classes
//   helpers    - op classification functions
package kamus_mem_pkg;

    typedef enum logic [5:0] {
        ADD = 6'd0,
        SUB = 6'd1,
        SLL = 6'd2,
        LUI = 6'd3,
        LB  = 6'd16,
        LH  = 6'd17,
        LW  = 6'd18,
        LBU = 6'd19,
        LHU = 6'd20,
        SB  = 6'd24,
        SH  = 6'd25,
        SW  = 6'd26
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    function automatic logic op_is_load(op_e op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic logic op_is_store(op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic op_is_mem(op_e op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    // Non-memory ops report WORD; callers gate on op_is_mem first.
    function automatic mem_size_e op_size(op_e op);
        case (op)
            LB, LBU, SB: return BYTE;
            LH, LHU, SH: return HALF;
            default:     return WORD;
        endcase
    endfunction

endpackage

// File: rtl/kamus_mem_if.sv
// Data-memory request/response bus.
//   master (memory stage): req, we, be, addr, wdata out; gnt, rvalid, rdata in
//   slave  (memory)      : the reverse
interface kamus_mem_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/kamus_lsu_align.sv
// Combinational load/store lane logic.
// Request side : req_op, req_offset (addr[1:0]), req_sdata ->
//                req_be, req_wdata (lane-replicated), req_misaligned
// Load side    : ld_op, ld_offset, ld_rdata -> ld_value (extracted, extended)
module kamus_lsu_align
    import kamus_mem_pkg::*;
(
    input  op_e         req_op,
    input  logic [1:0]  req_offset,
    input  logic [31:0] req_sdata,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,
    output logic        req_misaligned,
    input  op_e         ld_op,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_value
);

    logic [31:0] shifted;

    always_comb begin
        req_be         = '0;
        req_wdata      = '0;
        req_misaligned = 1'b0;
        case (op_size(req_op))
            BYTE: begin
                req_be    = 4'b0001 << req_offset;
                req_wdata = {4{req_sdata[7:0]}};
            end
            HALF: begin
                req_be         = 4'b0011 << req_offset;
                req_wdata      = {2{req_sdata[15:0]}};
                req_misaligned = req_offset[0];
            end
            default: begin
                req_be         = 4'hF;
                req_wdata      = req_sdata;
                req_misaligned = |req_offset;
            end
        endcase
    end

    always_comb begin
        shifted  = ld_rdata >> {ld_offset, 3'b000};
        ld_value = shifted;
        case (ld_op)
            LB:      ld_value = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     ld_value = {24'd0, shifted[7:0]};
            LH:      ld_value = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     ld_value = {16'd0, shifted[15:0]};
            default: ld_value = shifted;
        endcase
    end

endmodule

// File: rtl/kamus_mem.sv
// Memory-access stage: owns the EX/MEM register, issues loads/stores over
// the dmem bus and produces the writeback payload.
// Ports:
//   clk_i, rst_i (async, active-high)
//   valid_i, operation_i, ex_i, store_data_i, rd_addr_i : from EX
//   stall_o                                             : hold EX while busy
//   dmem (kamus_mem_if.master)                          : data-memory bus
//   wb_valid_o, wb_we_o, wb_rd_addr_o, wb_data_o        : to WB
//   misaligned_o, bus_err_o                             : 1-cycle fault pulses
module kamus_mem
    import kamus_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  op_e                operation_i,
    input  logic [31:0]        ex_i,
    input  logic [31:0]        store_data_i,
    input  logic [4:0]         rd_addr_i,
    output logic               stall_o,
    kamus_mem_if.master        dmem,
    output logic               wb_valid_o,
    output logic               wb_we_o,
    output logic [4:0]         wb_rd_addr_o,
    output logic [31:0]        wb_data_o,
    output logic               misaligned_o,
    output logic               bus_err_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state;
    logic [CNT_W-1:0] cnt;
    op_e              op_q;
    logic [1:0]       off_q;
    logic [4:0]       rd_q;

    logic             req_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic             misaligned_c;
    logic [31:0]      ld_value;

    kamus_lsu_align u_align (
        .req_op         (operation_i),
        .req_offset     (ex_i[1:0]),
        .req_sdata      (store_data_i),
        .req_be         (be_c),
        .req_wdata      (wdata_c),
        .req_misaligned (misaligned_c),
        .ld_op          (op_q),
        .ld_offset      (off_q),
        .ld_rdata       (dmem.rdata),
        .ld_value       (ld_value)
    );

    assign stall_o    = (state != IDLE);
    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.be    = be_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= ADD;
            off_q        <= '0;
            rd_q         <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wb_valid_o   <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_rd_addr_o <= '0;
            wb_data_o    <= '0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            wb_valid_o   <= 1'b0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    // stall_o is low in IDLE, so valid_i alone means accept.
                    if (valid_i) begin
                        if (!op_is_mem(operation_i)) begin
                            wb_valid_o   <= 1'b1;
                            wb_we_o      <= (rd_addr_i != '0);
                            wb_rd_addr_o <= rd_addr_i;
                            wb_data_o    <= ex_i;
                        end else if (misaligned_c) begin
                            misaligned_o <= 1'b1;
                            wb_valid_o   <= 1'b1;
                            wb_we_o      <= 1'b0;
                            wb_rd_addr_o <= rd_addr_i;
                            wb_data_o    <= '0;
                        end else begin
                            state   <= REQ;
                            cnt     <= '0;
                            op_q    <= operation_i;
                            off_q   <= ex_i[1:0];
                            rd_q    <= rd_addr_i;
                            req_q   <= 1'b1;
                            we_q    <= op_is_store(operation_i);
                            be_q    <= be_c;
                            addr_q  <= {ex_i[31:2], 2'b00};
                            wdata_q <= op_is_store(operation_i) ? wdata_c : '0;
                        end
                    end
                end
                REQ: begin
                    if (dmem.gnt) begin
                        state <= WAIT_R;
                        cnt   <= '0;
                        req_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= IDLE;
                        req_q        <= 1'b0;
                        bus_err_o    <= 1'b1;
                        wb_valid_o   <= 1'b1;
                        wb_we_o      <= 1'b0;
                        wb_rd_addr_o <= rd_q;
                        wb_data_o    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_R: begin
                    if (dmem.rvalid) begin
                        state        <= IDLE;
                        wb_valid_o   <= 1'b1;
                        wb_rd_addr_o <= rd_q;
                        wb_we_o      <= op_is_load(op_q) && (rd_q != '0);
                        wb_data_o    <= op_is_load(op_q) ? ld_value : '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= IDLE;
                        bus_err_o    <= 1'b1;
                        wb_valid_o   <= 1'b1;
                        wb_we_o      <= 1'b0;
                        wb_rd_addr_o <= rd_q;
                        wb_data_o    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kamus_mem.sv
// Self-checking bench for kamus_mem: directed scenarios followed by random
// ops checked against a byte-lane reference model.
module tb_kamus_mem;
    import kamus_mem_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    op_e         op = ADD;
    logic [31:0] ex = '0;
    logic [31:0] sd = '0;
    logic [4:0]  rd = '0;
    logic        stall;
    logic        wb_valid, wb_we, misaligned, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    kamus_mem_if dmem_bus ();

    kamus_mem #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .operation_i  (op),
        .ex_i         (ex),
        .store_data_i (sd),
        .rd_addr_i    (rd),
        .stall_o      (stall),
        .dmem         (dmem_bus),
        .wb_valid_o   (wb_valid),
        .wb_we_o      (wb_we),
        .wb_rd_addr_o (wb_rd),
        .wb_data_o    (wb_data),
        .misaligned_o (misaligned),
        .bus_err_o    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_bytes(op_e o);
        case (o)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit m_signed(op_e o);
        return (o == LB) || (o == LH);
    endfunction

    function automatic bit m_store(op_e o);
        return (o == SB) || (o == SH) || (o == SW);
    endfunction

    function automatic logic [3:0] m_be(int n, int off);
        logic [3:0] b = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(int n, logic [31:0] d);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(op_e o, int off, logic [31:0] rdata);
        int n = m_bytes(o);
        longint v = 0;
        for (int k = n - 1; k >= 0; k--)
            v = v * 256 + longint'((rdata >> (8 * (off + k))) & 32'hFF);
        if (m_signed(o) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One complete instruction: accept, bus handshake, writeback check.
    task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] r, input int gdly, input int rdly,
                          input logic [31:0] rdata);
        int n   = m_bytes(o);
        int off = int'(a % 4);
        logic [3:0]  e_be = m_be(n, off);
        logic [31:0] e_addr = a - (a % 4);
        chk("stall_before_accept", stall, 0);
        valid = 1'b1; op = o; ex = a; sd = d; rd = r;
        step();
        valid = 1'b0;
        if (n == 0) begin
            chk("alu_wb_valid", wb_valid, 1);
            chk("alu_wb_we", wb_we, r != 0);
            chk("alu_wb_data", wb_data, a);
            chk("alu_wb_rd", wb_rd, r);
            chk("alu_stall", stall, 0);
            return;
        end
        if ((a % n) != 0) begin
            chk("mis_pulse", misaligned, 1);
            chk("mis_wb_valid", wb_valid, 1);
            chk("mis_wb_we", wb_we, 0);
            chk("mis_no_req", dmem_bus.req, 0);
            chk("mis_stall", stall, 0);
            step();
            chk("mis_pulse_end", misaligned, 0);
            return;
        end
        chk("req_stall", stall, 1);
        chk("req_we", dmem_bus.we, m_store(o));
        for (int i = 0; i <= gdly; i++) begin
            if (i > 0) step();
            chk("req_held", dmem_bus.req, 1);
            chk("req_addr", dmem_bus.addr, e_addr);
            chk("req_be", dmem_bus.be, e_be);
            if (m_store(o)) chk("req_wdata", dmem_bus.wdata, m_wdata(n, d));
        end
        dmem_bus.gnt = 1'b1;
        step();
        dmem_bus.gnt = 1'b0;
        chk("gnt_req_drop", dmem_bus.req, 0);
        chk("gnt_stall", stall, 1);
        for (int i = 0; i < rdly; i++) begin
            step();
            chk("wait_no_wb", wb_valid, 0);
        end
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = rdata;
        step();
        dmem_bus.rvalid = 1'b0;
        chk("done_stall", stall, 0);
        chk("done_wb_valid", wb_valid, 1);
        chk("done_wb_rd", wb_rd, r);
        if (m_store(o)) begin
            chk("st_wb_we", wb_we, 0);
            chk("st_wb_data", wb_data, 0);
        end else begin
            chk("ld_wb_we", wb_we, r != 0);
            chk("ld_wb_data", wb_data, m_load(o, off, rdata));
        end
    endtask

    op_e ops [10] = '{ADD, SUB, LW, LH, LHU, LB, LBU, SW, SH, SB};

    initial begin
        int n_to;
        dmem_bus.gnt    = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = '0;

        // Reset state
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_bus.req, 0);
        chk("rst_be", dmem_bus.be, 0);
        chk("rst_addr", dmem_bus.addr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        step();
        step();
        rst = 1'b0;
        step();

        // ALU pass-through, no stall
        run_op(ADD, 32'h1234, 0, 5'd5, 0, 0, 0);
        step();
        chk("alu_pulse_end", wb_valid, 0);
        chk("alu_no_stall", stall, 0);

        // Byte loads at the top lane
        run_op(LB, 32'h1003, 0, 5'd7, 0, 0, 32'h80AABBCC);
        chk("lb_value", wb_data, 32'hFFFFFF80);
        run_op(LBU, 32'h1003, 0, 5'd7, 0, 0, 32'h80AABBCC);
        chk("lbu_value", wb_data, 32'h00000080);

        // Halfword store with delayed grant
        run_op(SH, 32'h2002, 32'hDEADBEEF, 5'd3, 3, 1, 0);

        // Misaligned word load
        run_op(LW, 32'h3001, 0, 5'd9, 0, 0, 0);

        // Response timeout, then a late rvalid must be ignored
        valid = 1'b1; op = LW; ex = 32'h40; rd = 5'd4;
        step();
        valid = 1'b0;
        dmem_bus.gnt = 1'b1;
        step();
        dmem_bus.gnt = 1'b0;
        n_to = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            step();
            if (bus_err === 1'b1) begin
                n_to = i;
                break;
            end
        end
        chk("timeout_latency", n_to, TO);
        chk("timeout_wb_valid", wb_valid, 1);
        chk("timeout_wb_we", wb_we, 0);
        chk("timeout_stall", stall, 0);
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'h5555AAAA;
        step();
        dmem_bus.rvalid = 1'b0;
        chk("late_rvalid_ignored", wb_valid, 0);
        step();
        chk("late_rvalid_ignored2", wb_valid, 0);

        // Asynchronous reset while waiting for the response
        valid = 1'b1; op = LW; ex = 32'h80; rd = 5'd6;
        step();
        valid = 1'b0;
        dmem_bus.gnt = 1'b1;
        step();
        dmem_bus.gnt = 1'b0;
        chk("pre_rst_stall", stall, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_req", dmem_bus.req, 0);
        chk("arst_addr", dmem_bus.addr, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_wb_rd", wb_rd, 0);
        step();
        rst = 1'b0;
        step();
        run_op(ADD, 32'hCAFEF00D, 0, 5'd11, 0, 0, 0);

        // Random ops against the model
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 3));
            run_op(ops[$urandom_range(0, 9)], a, $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
